din_debounce: RTL and testbench

//  Upstream conditioning stage for the edge detector. Synchronises an

---
 rtl/din_debounce.sv | 141 ++++++++++++++
 tb/tb_din_debounce.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/din_debounce.sv
// din_debounce: brings an asynchronous level into clk through a flop chain and
// debounces it, with a saturating count of the transitions it rejected.

module din_sync_ff #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic srst_n,
   input  logic d,
   output logic q
);
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) q <= RESET_VAL;
      else         q <= d;
   end
endmodule

module din_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8,
   parameter int GLITCH_W        = 8,
   parameter bit RESET_VAL       = 1'b0
) (
   input  logic                clk,
   input  logic                srst_n,
   input  logic                din_async,
   input  logic                en,
   input  logic                glitch_clr,
   output logic                dout,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);
   typedef enum logic [1:0] {
      ST_LO  = 2'd0,
      CHK_HI = 2'd1,
      ST_HI  = 2'd2,
      CHK_LO = 2'd3
   } state_t;

   localparam state_t           ST_RST   = RESET_VAL ? ST_HI : ST_LO;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   dout_d;
   logic                   glitch_inc;

   // Plain flop chain; en deliberately does not gate it so s stays current.
   generate
      for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
         if (i == 0) begin : g_first
            din_sync_ff #(.RESET_VAL(RESET_VAL)) u_ff (
               .clk(clk), .srst_n(srst_n), .d(din_async), .q(sync[i]));
         end else begin : g_next
            din_sync_ff #(.RESET_VAL(RESET_VAL)) u_ff (
               .clk(clk), .srst_n(srst_n), .d(sync[i-1]), .q(sync[i]));
         end
      end
   endgenerate

   assign s = sync[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dout_d     = dout;
      glitch_inc = 1'b0;
      if (en) begin
         case (state_q)
            ST_LO: begin
               if (s) begin
                  state_d = CHK_HI;
                  cnt_d   = CNT_ONE;
               end
            end
            CHK_HI: begin
               if (!s) begin
                  state_d    = ST_LO;
                  cnt_d      = '0;
                  glitch_inc = 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_HI;
                  dout_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_HI: begin
               if (!s) begin
                  state_d = CHK_LO;
                  cnt_d   = CNT_ONE;
               end
            end
            CHK_LO: begin
               if (s) begin
                  state_d    = ST_HI;
                  cnt_d      = '0;
                  glitch_inc = 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_LO;
                  dout_d  = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_RST;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state_q <= ST_RST;
         cnt_q   <= '0;
         dout    <= RESET_VAL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout    <= dout_d;
      end
   end

   // Clear beats a coincident increment; the count sticks at all-ones.
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n)                            glitch_cnt <= '0;
      else if (glitch_clr)                    glitch_cnt <= '0;
      else if (glitch_inc && glitch_cnt != '1) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
   end

   assign busy = (state_q == CHK_HI) || (state_q == CHK_LO);

endmodule

// File: tb/tb_din_debounce.sv
// Bench for din_debounce: per-cycle vector table checked through a scoreboard,
// plus hand-written sequences for reset, saturation and the RESET_VAL=1 build.

module tb_din_debounce;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, din, en, clr, dout, busy;
   logic [7:0] gcnt;
   logic       rst2_n, din2, clr2, dout2, busy2;
   logic [1:0] gcnt2;
   logic       din3, dout3, busy3;
   logic [7:0] gcnt3;
   logic       en_aux;

   din_debounce u_dut (
      .clk(clk), .srst_n(rst_n), .din_async(din), .en(en), .glitch_clr(clr),
      .dout(dout), .busy(busy), .glitch_cnt(gcnt));

   din_debounce #(.GLITCH_W(2)) u_g2 (
      .clk(clk), .srst_n(rst2_n), .din_async(din2), .en(en_aux), .glitch_clr(clr2),
      .dout(dout2), .busy(busy2), .glitch_cnt(gcnt2));

   din_debounce #(.RESET_VAL(1'b1)) u_r1 (
      .clk(clk), .srst_n(rst2_n), .din_async(din3), .en(en_aux), .glitch_clr(1'b0),
      .dout(dout3), .busy(busy3), .glitch_cnt(gcnt3));

   typedef struct packed {
      logic       din, en, clr, dout, busy;
      logic [7:0] glitch;
   } vec_t;

   typedef struct packed {
      logic [15:0] idx;
      logic        dout, busy;
      logic [7:0]  glitch;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   function automatic vec_t mk(input logic d, input logic en_v, input logic c,
                               input logic od, input logic ob, input logic [7:0] g);
      mk = '{din: d, en: en_v, clr: c, dout: od, busy: ob, glitch: g};
   endfunction

   // Each vector is driven on a falling edge and judged just after the next rise.
   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      din = v.din;
      en  = v.en;
      clr = v.clr;
      sb.push_back('{idx: 16'(idx), dout: v.dout, busy: v.busy, glitch: v.glitch});
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("vec%0d {dout,busy,glitch}", e.idx),
               {22'b0, dout, busy, gcnt}, {22'b0, e.dout, e.busy, e.glitch});
      end
   end

   task automatic g2_glitch(input logic clr_at_inc);
      @(negedge clk); din2 = 1'b1; clr2 = 1'b0;
      @(negedge clk); din2 = 1'b1;
      @(negedge clk); din2 = 1'b0;
      @(negedge clk);
      @(negedge clk); clr2 = clr_at_inc;
      @(negedge clk); clr2 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; din = 1'b0; en = 1'b1; clr = 1'b0;
      rst2_n = 1'b0; din2 = 1'b0; clr2 = 1'b0; din3 = 1'b1; en_aux = 1'b1;

      // rising edge qualifies after SYNC_STAGES + DEBOUNCE_CYCLES edges
      repeat (2) vecs.push_back(mk(1, 1, 0, 0, 0, 0));
      repeat (3) vecs.push_back(mk(1, 1, 0, 0, 1, 0));
      repeat (2) vecs.push_back(mk(1, 1, 0, 1, 0, 0));
      // three lows, one high, then low held: one glitch, then a clean fall
      vecs.push_back(mk(0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 1, 0));
      vecs.push_back(mk(1, 1, 0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 1));
      repeat (3) vecs.push_back(mk(0, 1, 0, 1, 1, 1));
      repeat (2) vecs.push_back(mk(0, 1, 0, 0, 0, 1));
      // two-cycle high pulse is rejected
      repeat (2) vecs.push_back(mk(1, 1, 0, 0, 0, 1));
      repeat (2) vecs.push_back(mk(0, 1, 0, 0, 1, 1));
      repeat (2) vecs.push_back(mk(0, 1, 0, 0, 0, 2));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0));
      // freeze in CHK_HI with cnt=2, then resume
      repeat (2) vecs.push_back(mk(1, 1, 0, 0, 0, 0));
      repeat (2) vecs.push_back(mk(1, 1, 0, 0, 1, 0));
      repeat (10) vecs.push_back(mk(1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 0));
      repeat (2) vecs.push_back(mk(1, 1, 0, 1, 0, 0));
      // freeze in CHK_LO, input reverses while frozen: glitch on resume
      repeat (2) vecs.push_back(mk(0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 1, 0));
      repeat (3) vecs.push_back(mk(1, 0, 0, 1, 1, 0));
      repeat (2) vecs.push_back(mk(1, 1, 0, 1, 0, 1));

      #12;
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_glitch", 32'(gcnt), 32'd0);
      check("rst_g2_glitch", 32'(gcnt2), 32'd0);
      check("rst_r1_dout", 32'(dout3), 32'd1);
      check("rst_r1_busy", 32'(busy3), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; rst2_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
      for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
      check("scoreboard_drain", 32'(sb.size()), 32'd0);

      check("r1_hold_dout", 32'(dout3), 32'd1);
      check("r1_hold_busy", 32'(busy3), 32'd0);

      // async reset in the middle of CHK_HI
      @(negedge clk); din = 1'b0; en = 1'b1;
      repeat (7) @(negedge clk);
      check("t6_pre_dout", 32'(dout), 32'd0);
      din = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t6_pre_busy", 32'(busy), 32'd1);
      check("t6_pre_glitch", 32'(gcnt), 32'd1);
      #2; rst_n = 1'b0; #1;
      check("t6_async_dout", 32'(dout), 32'd0);
      check("t6_async_busy", 32'(busy), 32'd0);
      check("t6_async_glitch", 32'(gcnt), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("t6_requal_e5_dout", 32'(dout), 32'd0);
      check("t6_requal_e5_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("t6_requal_e6_dout", 32'(dout), 32'd1);

      // 2-bit glitch counter saturation and clear-beats-increment
      repeat (3) g2_glitch(1'b0);
      check("g2_three", 32'(gcnt2), 32'd3);
      repeat (2) g2_glitch(1'b0);
      check("g2_saturate", 32'(gcnt2), 32'd3);
      check("g2_dout", 32'(dout2), 32'd0);
      g2_glitch(1'b1);
      check("g2_clr_wins", 32'(gcnt2), 32'd0);
      g2_glitch(1'b0);
      check("g2_after_clr", 32'(gcnt2), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
